ex_mul_sequencer: RTL and testbench

//   Multi-cycle controller for integer multiply in the EX stage. On a MUL opcode it

---
 rtl/ex_mul_sequencer.sv | 160 ++++++++++++++++
 tb/tb_ex_mul_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mul_sequencer.sv
// ex_mul_sequencer: multi-cycle unsigned shift-add multiply controller for the EX stage.
// It captures both EX operands on a MUL opcode and processes one multiplier bit per cycle.
// While the multiply runs it stalls IF/ID/EX. It then presents the product and the
// N/Z/V flags for one cycle in place of the ALU result.
// Optional feature: define EARLY_TERM_EN so that RUN ends as soon as no set multiplier
// bits remain. The results are the same in both builds; only the latency changes.
module ex_mul_sequencer #(
  parameter int          WIDTH   = 32,
  parameter logic [5:0]  OPC_MUL = 6'b001010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [5:0]       opcode,
  input  logic [WIDTH-1:0] ALU_input_1,
  input  logic [WIDTH-1:0] ALU_input_2,
  input  logic             flush,
  output logic             stall_out,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] MUL_out,
  output logic             N_out,
  output logic             Z_out,
  output logic             V_out
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t               state_r;
  logic [2*WIDTH-1:0]   mcand_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]     mplier_r;
  logic [CW-1:0]        cnt_r;
  logic                 busy_r;
  logic                 result_valid_r;
  logic [WIDTH-1:0]     mul_out_r;
  logic                 n_r;
  logic                 z_r;
  logic                 v_r;

  logic                 start_s;
  logic                 last_s;
  logic                 stall_s;
  logic [2*WIDTH-1:0]   acc_next_s;
  logic [2:0]           flags_s;

  // Derives {N, Z, V} from the full 2*WIDTH-bit product.
  function automatic logic [2:0] calc_flags(input logic [2*WIDTH-1:0] prod);
    logic n_f;
    logic z_f;
    logic v_f;
    n_f = prod[WIDTH-1];
    z_f = (prod[WIDTH-1:0] == {WIDTH{1'b0}});
    v_f = (prod[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
    return {n_f, z_f, v_f};
  endfunction

  // Start decode, the accumulate step, the RUN exit condition and the stall request.
  always_comb begin
    start_s    = ex_valid & (opcode == OPC_MUL);
    acc_next_s = acc_r;
    if (mplier_r[0]) begin
      acc_next_s = acc_r + mcand_r;
    end else begin
      acc_next_s = acc_r;
    end
`ifdef EARLY_TERM_EN
    // The remaining multiplier bits are all zero, so later iterations would add nothing.
    last_s = (cnt_r == CNT_LAST) | ((mplier_r >> 1) == {WIDTH{1'b0}});
`else
    last_s = (cnt_r == CNT_LAST);
`endif
    stall_s = ((state_r == IDLE) & start_s) | (state_r == RUN);
    flags_s = calc_flags(acc_next_s);
  end

  // FSM, datapath and registered result/flag outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      mcand_r        <= {(2*WIDTH){1'b0}};
      acc_r          <= {(2*WIDTH){1'b0}};
      mplier_r       <= {WIDTH{1'b0}};
      cnt_r          <= {CW{1'b0}};
      busy_r         <= 1'b0;
      result_valid_r <= 1'b0;
      mul_out_r      <= {WIDTH{1'b0}};
      n_r            <= 1'b0;
      z_r            <= 1'b0;
      v_r            <= 1'b0;
    end else if (flush) begin
      // A redirect kills the operation. The last published result is kept.
      state_r        <= IDLE;
      busy_r         <= 1'b0;
      result_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          result_valid_r <= 1'b0;
          if (start_s) begin
            mcand_r  <= {{WIDTH{1'b0}}, ALU_input_1};
            mplier_r <= ALU_input_2;
            acc_r    <= {(2*WIDTH){1'b0}};
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b1;
            state_r  <= RUN;
          end else begin
            busy_r   <= 1'b0;
            state_r  <= IDLE;
          end
        end
        RUN: begin
          acc_r    <= acc_next_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + CW'(1);
          busy_r   <= 1'b1;
          if (last_s) begin
            mul_out_r      <= acc_next_s[WIDTH-1:0];
            n_r            <= flags_s[2];
            z_r            <= flags_s[1];
            v_r            <= flags_s[0];
            result_valid_r <= 1'b1;
            state_r        <= DONE;
          end else begin
            result_valid_r <= 1'b0;
            state_r        <= RUN;
          end
        end
        DONE: begin
          // This MUL is still in EX during DONE, so start is ignored here.
          result_valid_r <= 1'b0;
          busy_r         <= 1'b0;
          state_r        <= IDLE;
        end
        default: begin
          result_valid_r <= 1'b0;
          busy_r         <= 1'b0;
          state_r        <= IDLE;
        end
      endcase
    end
  end

  assign stall_out    = stall_s;
  assign busy         = busy_r;
  assign result_valid = result_valid_r;
  assign MUL_out      = mul_out_r;
  assign N_out        = n_r;
  assign Z_out        = z_r;
  assign V_out        = v_r;

endmodule

// File: tb/tb_ex_mul_sequencer.sv
// Directed testbench for ex_mul_sequencer (WIDTH=32). Expected values are hand-computed.
module tb_ex_mul_sequencer;

  localparam logic [5:0] OPC = 6'b001010;
`ifdef EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [5:0]  opcode;
  logic [31:0] ALU_input_1;
  logic [31:0] ALU_input_2;
  logic        flush;
  logic        stall_out;
  logic        busy;
  logic        result_valid;
  logic [31:0] MUL_out;
  logic        N_out;
  logic        Z_out;
  logic        V_out;

  int errors;
  int checks;

  ex_mul_sequencer #(.WIDTH(32), .OPC_MUL(OPC)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .opcode(opcode),
    .ALU_input_1(ALU_input_1), .ALU_input_2(ALU_input_2), .flush(flush),
    .stall_out(stall_out), .busy(busy), .result_valid(result_valid),
    .MUL_out(MUL_out), .N_out(N_out), .Z_out(Z_out), .V_out(V_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The stall must cover T..T+32 in the fixed build. In the early-term build it
  // follows the highest set multiplier bit.
  function automatic int exp_cycles(input int early_val);
    return EARLY ? early_val : 33;
  endfunction

  // Drives one MUL and follows it until result_valid is seen.
  // Returns the number of cycles from T to DONE and the observed outputs.
  // bad counts cycles in which stall_out or busy had the wrong value.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                        output int cycles, output logic [31:0] mo,
                        output logic nf, output logic zf, output logic vf,
                        output int bad);
    bad = 0;
    cycles = 0;
    @(negedge clk);
    ex_valid = 1'b1; opcode = OPC; ALU_input_1 = a; ALU_input_2 = b; flush = 1'b0;
    #1;
    if (stall_out !== 1'b1 || busy !== 1'b0) bad++;
    while (cycles < 100) begin
      @(negedge clk);
      cycles++;
      ALU_input_1 = ~a;
      ALU_input_2 = ~b;
      #1;
      if (result_valid === 1'b1) break;
      if (stall_out !== 1'b1 || busy !== 1'b1) bad++;
    end
    if (stall_out !== 1'b0 || busy !== 1'b1) bad++;
    mo = MUL_out; nf = N_out; zf = Z_out; vf = V_out;
  endtask

  task automatic go_idle();
    @(negedge clk);
    ex_valid = 1'b0; opcode = 6'b000000; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ex_valid = 1'b0; opcode = 6'b000000; flush = 1'b0;
    ALU_input_1 = 32'h0; ALU_input_2 = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({stall_out, busy, result_valid, N_out, Z_out, V_out} !== 6'b000000 || MUL_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got stall=%b busy=%b rv=%b mul=%h nzv=%b%b%b, want all 0",
               stall_out, busy, result_valid, MUL_out, N_out, Z_out, V_out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_non_mul();
    int bad;
    bad = 0;
    @(negedge clk);
    ex_valid = 1'b1; opcode = 6'b000001;
    repeat (3) begin
      @(negedge clk); #1;
      if (stall_out !== 1'b0 || busy !== 1'b0) bad++;
    end
    ex_valid = 1'b0; opcode = OPC;
    repeat (2) begin
      @(negedge clk); #1;
      if (stall_out !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL non_mul_no_stall: got %0d bad cycles, want 0", bad);
    end
    go_idle();
  endtask

  task automatic test_basic();
    int cyc; int bad; logic [31:0] mo; logic n, z, v;
    do_mul(32'd3, 32'd5, cyc, mo, n, z, v, bad);
    checks++;
    if (cyc !== exp_cycles(4)) begin
      errors++; $display("FAIL basic_latency: got %0d, want %0d", cyc, exp_cycles(4));
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL basic_stall: got %0d bad cycles, want 0", bad);
    end
    checks++;
    if (mo !== 32'd15 || {n, z, v} !== 3'b000) begin
      errors++; $display("FAIL basic_result: got %h nzv=%b%b%b, want 0000000f nzv=000", mo, n, z, v);
    end
    go_idle();
    #1;
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_one_cycle_valid: got rv=%b busy=%b, want 0 0", result_valid, busy);
    end
  endtask

  task automatic test_flags();
    int cyc; int bad; logic [31:0] mo; logic n, z, v;
    do_mul(32'h0001_0000, 32'h0001_0000, cyc, mo, n, z, v, bad);
    checks++;
    if (mo !== 32'h0 || {n, z, v} !== 3'b011 || cyc !== exp_cycles(18) || bad !== 0) begin
      errors++; $display("FAIL flags_2p32: got %h nzv=%b%b%b cyc=%0d bad=%0d, want 00000000 nzv=011 cyc=%0d",
                         mo, n, z, v, cyc, bad, exp_cycles(18));
    end
    go_idle();
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, mo, n, z, v, bad);
    checks++;
    if (mo !== 32'h0000_0001 || {n, z, v} !== 3'b001 || cyc !== 33 || bad !== 0) begin
      errors++; $display("FAIL flags_allones: got %h nzv=%b%b%b cyc=%0d bad=%0d, want 00000001 nzv=001 cyc=33",
                         mo, n, z, v, cyc, bad);
    end
    go_idle();
    do_mul(32'd7, 32'h8000_0000, cyc, mo, n, z, v, bad);
    checks++;
    if (mo !== 32'h8000_0000 || {n, z, v} !== 3'b101 || cyc !== 33 || bad !== 0) begin
      errors++; $display("FAIL flags_msb: got %h nzv=%b%b%b cyc=%0d bad=%0d, want 80000000 nzv=101 cyc=33",
                         mo, n, z, v, cyc, bad);
    end
    go_idle();
    do_mul(32'h0000_1234, 32'h0, cyc, mo, n, z, v, bad);
    checks++;
    if (mo !== 32'h0 || {n, z, v} !== 3'b010 || cyc !== exp_cycles(2) || bad !== 0) begin
      errors++; $display("FAIL mul_by_zero: got %h nzv=%b%b%b cyc=%0d bad=%0d, want 00000000 nzv=010 cyc=%0d",
                         mo, n, z, v, cyc, bad, exp_cycles(2));
    end
    go_idle();
    do_mul(32'd7, 32'h8000_0000, cyc, mo, n, z, v, bad);
    go_idle();
  endtask

  task automatic test_flush();
    int rv_seen;
    @(negedge clk);
    ex_valid = 1'b1; opcode = OPC; ALU_input_1 = 32'd5; ALU_input_2 = 32'hFFFF_FFFF;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 10) begin
        flush = 1'b1; ex_valid = 1'b0;
      end
    end
    #1;
    checks++;
    if (stall_out !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL flush_in_run: got stall=%b busy=%b, want 1 1", stall_out, busy);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if (stall_out !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0 || MUL_out !== 32'h8000_0000) begin
      errors++; $display("FAIL flush_idle: got stall=%b busy=%b rv=%b mul=%h, want 0 0 0 80000000",
                         stall_out, busy, result_valid, MUL_out);
    end
    rv_seen = 0;
    repeat (40) begin
      @(negedge clk); #1;
      if (result_valid === 1'b1 || busy !== 1'b0) rv_seen++;
    end
    checks++;
    if (rv_seen !== 0) begin
      errors++; $display("FAIL flush_no_result: got %0d active cycles, want 0", rv_seen);
    end
    @(negedge clk);
    ex_valid = 1'b1; opcode = OPC; flush = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || stall_out !== 1'b0) begin
      errors++; $display("FAIL flush_beats_start: got busy=%b stall=%b, want 0 0", busy, stall_out);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc; int bad; logic [31:0] mo; logic n, z, v;
    @(negedge clk);
    ex_valid = 1'b1; opcode = OPC; ALU_input_1 = 32'd3; ALU_input_2 = 32'hFFFF_FFFF;
    repeat (5) @(negedge clk);
    rst = 1'b1; ex_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({stall_out, busy, result_valid, N_out, Z_out, V_out} !== 6'b000000 || MUL_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_run: got stall=%b busy=%b rv=%b mul=%h nzv=%b%b%b, want all 0",
               stall_out, busy, result_valid, MUL_out, N_out, Z_out, V_out);
    end
    do_mul(32'd2, 32'd9, cyc, mo, n, z, v, bad);
    checks++;
    if (mo !== 32'd18 || {n, z, v} !== 3'b000 || cyc !== exp_cycles(5) || bad !== 0) begin
      errors++; $display("FAIL after_reset_mul: got %h nzv=%b%b%b cyc=%0d bad=%0d, want 00000012 nzv=000 cyc=%0d",
                         mo, n, z, v, cyc, bad, exp_cycles(5));
    end
    go_idle();
  endtask

  task automatic test_back_to_back();
    int cyc; int bad; logic [31:0] mo; logic n, z, v;
    do_mul(32'd6, 32'd7, cyc, mo, n, z, v, bad);
    checks++;
    if (mo !== 32'd42 || cyc !== exp_cycles(4) || bad !== 0) begin
      errors++; $display("FAIL b2b_first: got %h cyc=%0d bad=%0d, want 0000002a cyc=%0d",
                         mo, cyc, bad, exp_cycles(4));
    end
    do_mul(32'h10, 32'h20, cyc, mo, n, z, v, bad);
    checks++;
    if (mo !== 32'h200 || {n, z, v} !== 3'b000 || cyc !== exp_cycles(7) || bad !== 0) begin
      errors++; $display("FAIL b2b_second: got %h nzv=%b%b%b cyc=%0d bad=%0d, want 00000200 nzv=000 cyc=%0d",
                         mo, n, z, v, cyc, bad, exp_cycles(7));
    end
    go_idle();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_non_mul();
    test_basic();
    test_flags();
    test_flush();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
